// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: issues single-cycle enable strobes every P clock cycles,
// either for a finite burst or continuously, until aborted. All outputs are
// registered. Intended to drive the enable of a downstream toggle flop.
module toggle_pulse_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] burst_len,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] per_q, per_d;   // latched effective period
  logic [CNT_W-1:0] len_q, len_d;   // latched burst length (0 = continuous)
  logic [DIV_W-1:0] div_q, div_d;   // cycles remaining until the next strobe
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] eff_period;
  logic [CNT_W-1:0] cnt_inc;

  assign eff_period = (period == '0) ? DIV_ONE : period;
  assign cnt_inc    = cnt_q + CNT_ONE;

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      len_q   <= len_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic. The divider holds the distance to the
  // next strobe; a strobe is registered on the edge where it reaches one, so
  // the strobe appears exactly P cycles after the accepting edge.
  // NOTE: every *_d gets a default before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    len_d   = len_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          per_d   = eff_period;
          len_d   = burst_len;
          if (eff_period == DIV_ONE) begin
            // P = 1: the very first RUN cycle already carries a strobe.
            div_d  = DIV_ONE;
            en_d   = 1'b1;
            cnt_d  = CNT_ONE;
            done_d = (burst_len == CNT_ONE);
          end else begin
            div_d = eff_period - DIV_ONE;
            cnt_d = '0;
          end
        end
      end

      RUN: begin
        if (stop || done_q) begin
          // Abort or natural end: leave RUN, suppress any pending strobe,
          // keep the pulse count visible.
          state_d = IDLE;
        end else if (div_q == DIV_ONE) begin
          en_d   = 1'b1;
          cnt_d  = cnt_inc;
          div_d  = per_q;
          done_d = (len_q != '0) && (cnt_inc == len_q);
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign en        = en_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen. Each step pushes the outputs
// expected in the next cycle onto a scoreboard queue, clocks the design, then
// pops and compares. Expectations come from a schedule model: for a start
// accepted in cycle 0, cycle k carries a strobe when k is a multiple of P and
// the burst (L*P cycles long, unbounded if L = 0) has not ended.
module tb_toggle_pulse_gen;

  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] burst_len;
  logic             en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  logic             tog = 1'b0;   // downstream toggle flop driven by en
  logic             tog_snap;

  int               n_assert = 0;
  int               n_fail   = 0;

  // Scoreboard entries: {en, busy, done, pulse_cnt}
  logic [CNT_W+2:0] exp_q[$];

  toggle_pulse_gen #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .burst_len (burst_len),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tog <= tog ^ en;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Expected outputs in cycle k (k >= 1) after a start accepted in cycle 0.
  function automatic logic [CNT_W+2:0] model(input int p, input int l, input int k);
    int   last;
    int   pulses;
    logic e_en, e_busy, e_done;
    last   = l * p;
    e_busy = (l == 0) || (k <= last);
    e_en   = e_busy && ((k % p) == 0);
    e_done = (l != 0) && (k == last);
    pulses = k / p;
    if (l != 0 && pulses > l) pulses = l;
    return {e_en, e_busy, e_done, pulses[CNT_W-1:0]};
  endfunction

  function automatic logic [CNT_W+2:0] idle_exp(input int cnt);
    return {1'b0, 1'b0, 1'b0, cnt[CNT_W-1:0]};
  endfunction

  // Push expectation for the next cycle, clock, pop and compare.
  task automatic step(input string tag, input logic [CNT_W+2:0] expv);
    logic [CNT_W+2:0] got;
    logic [CNT_W+2:0] want;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    got  = {en, busy, done, pulse_cnt};
    want = exp_q.pop_front();
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: en/busy/done/cnt observed %b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, got[CNT_W+2], got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
             want[CNT_W+2], want[CNT_W+1], want[CNT_W], want[CNT_W-1:0]);
    end
  endtask

  // Accept a start with the given fields, then follow the sequence for n
  // cycles while scrambling period/burst_len (they must not matter once
  // busy). With hold_start the start request stays high throughout.
  task automatic run_seq(input string tag, input int p_in, input int l_in,
                         input int n, input bit hold_start);
    int pe;
    pe        = (p_in == 0) ? 1 : p_in;
    period    = p_in[DIV_W-1:0];
    burst_len = l_in[CNT_W-1:0];
    start     = 1'b1;
    stop      = 1'b0;
    for (int k = 1; k <= n; k++) begin
      step(tag, model(pe, l_in, k));
      if (!hold_start) start = 1'b0;
      period    = DIV_W'($urandom);
      burst_len = CNT_W'($urandom);
    end
    start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    stop      = 1'b0;
    period    = 16'd2;
    burst_len = 8'd1;

    // Reset dominates a simultaneous start.
    step("reset_with_start", idle_exp(0));
    step("reset_hold", idle_exp(0));
    rst   = 1'b0;
    start = 1'b0;
    step("idle_after_reset", idle_exp(0));
    step("idle_quiet", idle_exp(0));

    // period 4, burst 3: strobes at +4, +8, +12, done at +12, count held.
    run_seq("p4_l3", 4, 3, 15, 1'b0);

    // period 0 acts as 1: strobes in every cycle 1..5, done at 5.
    run_seq("p0_l5", 0, 5, 7, 1'b0);

    // Single pulse with P = 1: done in the first RUN cycle.
    run_seq("p1_l1", 1, 1, 3, 1'b0);

    // Continuous, period 3: count wraps after 256 pulses while busy stays up.
    run_seq("p3_cont", 3, 0, 772, 1'b0);
    stop = 1'b1;
    step("p3_cont_stop", idle_exp(257 % 256));
    stop = 1'b0;
    step("p3_cont_idle", idle_exp(1));

    // period 5, burst 10: stop at the edge launching the 2nd strobe.
    run_seq("p5_l10", 5, 10, 9, 1'b0);
    stop = 1'b1;
    step("p5_l10_stop_suppress", idle_exp(1));
    stop = 1'b0;
    step("p5_l10_idle", idle_exp(1));

    // start held through the whole burst including its final cycle.
    run_seq("p2_l3_hold", 2, 3, 7, 1'b1);
    start     = 1'b1;
    stop      = 1'b1;
    period    = 16'd1;
    burst_len = 8'd4;
    step("idle_start_and_stop", idle_exp(3));
    start = 1'b0;
    stop  = 1'b0;
    step("idle_after_both", idle_exp(3));

    // Reset mid-RUN with period 2: nothing further reaches the toggle flop.
    run_seq("p2_cont", 2, 0, 5, 1'b0);
    rst = 1'b1;
    step("rst_mid_run", idle_exp(0));
    tog_snap = tog;
    start    = 1'b1;
    step("rst_over_start", idle_exp(0));
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) step("post_rst_idle", idle_exp(0));
    n_assert++;
    assert (tog === tog_snap) else begin
      n_fail++;
      $error("FAIL toggle_after_rst: toggle observed %b expected %b", tog, tog_snap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
